// File: rtl/sync_filter.sv
// Multi-channel synchroniser with per-channel stability filter: STAGES-deep flop chain, then
// FILTER-cycle persistence before out follows. Define SYNC_EDGE_EN to add rise/fall strobes.
module sync_filter #(
  parameter int unsigned      WIDTH  = 1,
  parameter int unsigned      STAGES = 3,
  parameter int unsigned      FILTER = 4,
  parameter logic [WIDTH-1:0] INIT   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
`ifdef SYNC_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  localparam int unsigned     CW       = $clog2(FILTER + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER - 1);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] chain_q;
  logic [STAGES-1:0][WIDTH-1:0] chain_d;
  logic [WIDTH-1:0]             s;
  logic [WIDTH-1:0]             out_q, out_d;
  logic [WIDTH-1:0]             upd;
  logic [WIDTH-1:0][CW-1:0]     cnt_q, cnt_d;

  // Pure shift: nothing may sit between synchroniser flops.
  assign chain_d = {chain_q[STAGES-2:0], in};
  assign s       = chain_q[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {STAGES{INIT}};
    end else begin
      chain_q <= chain_d;
    end
  end

  // Counter restarts on every return to the out level and is cleared on update, so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    upd   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        upd[i]   = 1'b1;
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign out_d = (out_q & ~upd) | (s & upd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= INIT;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out = out_q;

`ifdef SYNC_EDGE_EN
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  assign rise_d = ~out_q &  s & upd;
  assign fall_d =  out_q & ~s & upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: tb/tb_sync_filter.sv
// Scoreboard bench for sync_filter: three instances (defaults, WIDTH=4, FILTER=1) share one
// 6-bit stimulus vector; expected output updates are queued when stimulus is driven.
module tb_sync_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] drv;

  logic       o0, o1;
  logic [3:0] o4;
  logic [5:0] out_all;
`ifdef SYNC_EDGE_EN
  logic       r0, f0, r1, f1;
  logic [3:0] r4, f4;
  logic [5:0] rise_all, fall_all;
`endif

  sync_filter u0 (
    .clk(clk), .rst_n(rst_n), .in(drv[0]), .out(o0)
`ifdef SYNC_EDGE_EN
    , .rise(r0), .fall(f0)
`endif
  );

  sync_filter #(.WIDTH(4), .INIT(4'hF)) u4 (
    .clk(clk), .rst_n(rst_n), .in(drv[4:1]), .out(o4)
`ifdef SYNC_EDGE_EN
    , .rise(r4), .fall(f4)
`endif
  );

  sync_filter #(.FILTER(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in(drv[5]), .out(o1)
`ifdef SYNC_EDGE_EN
    , .rise(r1), .fall(f1)
`endif
  );

  assign out_all = {o1, o4, o0};
`ifdef SYNC_EDGE_EN
  assign rise_all = {r1, r4, r0};
  assign fall_all = {f1, f4, f0};
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   e;
    int   ch;
    logic v;
  } item_t;

  item_t      q[$];
  logic [5:0] exp_out  = '1;
  logic [5:0] exp_rise = '0;
  logic [5:0] exp_fall = '0;
  bit         running  = 1'b0;
  int         n_chk    = 0;
  int         n_err    = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  function automatic int lat(input int ch);
    return (ch == 5) ? 4 : 7;
  endfunction

  task automatic set_in(input logic [5:0] v, input bit push);
    for (int i = 0; i < 6; i++) begin
      if (push && (v[i] != drv[i])) q.push_back('{e: cyc + lat(i), ch: i, v: v[i]});
    end
    drv = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    #2;
    q.delete();
    exp_out = '1;
    rst_n   = 1'b0;
    #1;
    check("rst_async_out", out_all, 6'h3F);
`ifdef SYNC_EDGE_EN
    check("rst_async_rise", rise_all, 6'h00);
    check("rst_async_fall", fall_all, 6'h00);
`endif
    wait_cyc(hold);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (drv[i] != 1'b1) q.push_back('{e: cyc + lat(i), ch: i, v: drv[i]});
    end
  endtask

  always @(negedge clk) begin
    logic [5:0] nxt;
    if (running) begin
      nxt = exp_out;
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (q[k].e == cyc) begin
          nxt[q[k].ch] = q[k].v;
          q.delete(k);
        end else if (q[k].e < cyc) begin
          check("update_timeout", 8'(q[k].ch), 8'hFF);
          q.delete(k);
        end
      end
      exp_rise = ~exp_out & nxt;
      exp_fall = exp_out & ~nxt;
      exp_out  = nxt;
      check("out", out_all, exp_out);
`ifdef SYNC_EDGE_EN
      check("rise", rise_all, exp_rise);
      check("fall", fall_all, exp_fall);
      check("rise_fall_excl", rise_all & fall_all, 8'h00);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    drv     = 6'h00;
    running = 1'b1;
    wait_cyc(3);
    // Release with all inputs low: every channel falls after its full latency.
    do_reset(0);
    wait_cyc(12);
    set_in(6'h3F, 1'b1);
    wait_cyc(12);

    // Clean steps: 7 edges on the default instance, 4 with FILTER=1.
    set_in(6'h1E, 1'b1);
    wait_cyc(12);
    set_in(6'h3F, 1'b1);
    wait_cyc(12);

    // Three-cycle low pulse is rejected.
    set_in(6'h3E, 1'b0);
    wait_cyc(3);
    set_in(6'h3F, 1'b0);
    wait_cyc(10);

    // Four-cycle low pulse passes through both ways.
    set_in(6'h3E, 1'b1);
    wait_cyc(4);
    set_in(6'h3F, 1'b1);
    wait_cyc(14);

    // Bounce every 2 cycles; even number of toggles ends at the idle level.
    for (int t = 0; t < 24; t++) begin
      set_in(drv ^ 6'h01, 1'b0);
      wait_cyc(2);
    end
    wait_cyc(10);

    // WIDTH=4: 1111 -> 0101, then bit0 glitched low for 2 cycles.
    set_in(6'h2B, 1'b1);
    wait_cyc(2);
    set_in(6'h29, 1'b0);
    wait_cyc(2);
    set_in(6'h2B, 1'b0);
    wait_cyc(12);
    set_in(6'h3F, 1'b1);
    wait_cyc(12);

    // Reset while the default channel's counter sits at 2; latency restarts after release.
    set_in(6'h1E, 1'b1);
    wait_cyc(5);
    do_reset(3);
    wait_cyc(12);
    set_in(6'h3F, 1'b1);
    wait_cyc(12);

    check("queue_drained", 8'(q.size()), 8'h00);
    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
